// File: rtl/dmem_arbiter_if.sv
// Bundle between the two data-memory requesters, the arbiter and the single-port memory.
// The arbiter uses the slave view. The requesters and the memory use the master view.
interface dmem_arbiter_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);
  logic          req0;
  logic          req1;
  logic          we0;
  logic          we1;
  logic          lock0;
  logic          lock1;
  logic [AW-1:0] addr0;
  logic [AW-1:0] addr1;
  logic [DW-1:0] wdata0;
  logic [DW-1:0] wdata1;
  logic          gnt0;
  logic          gnt1;
  logic          rvalid0;
  logic          rvalid1;
  logic [DW-1:0] rdata0;
  logic [DW-1:0] rdata1;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  req0, req1, we0, we1, lock0, lock1, addr0, addr1, wdata0, wdata1, mem_rdata,
    output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req0, req1, we0, we1, lock0, lock1, addr0, addr1, wdata0, wdata1, mem_rdata,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter that shares one synchronous data memory between the CPU (port 0) and the loader (port 1).
// A port can lock the bus, but only for a bounded number of cycles. Read data returns one cycle after the grant.
module dmem_arbiter #(
  parameter int unsigned AW       = 32,
  parameter int unsigned DW       = 32,
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic           clk,
  input  logic           reset,
  dmem_arbiter_if.slave  bus
);

  localparam int unsigned HCW = $clog2(MAX_HOLD + 1);

  typedef enum logic [1:0] {S_IDLE, S_OWN0, S_OWN1} state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic           r_last_gnt;
  logic           w_last_nxt;
  logic [HCW-1:0] r_hold_cnt;
  logic [HCW-1:0] w_hold_nxt;
  logic [HCW-1:0] w_hold_inc;
  logic           r_rvalid0;
  logic           r_rvalid1;
  logic           w_gnt0;
  logic           w_gnt1;
  logic           w_mem_en;
  logic           w_mem_we;
  logic [AW-1:0]  w_mem_addr;
  logic [DW-1:0]  w_mem_wdata;

  // State register. It also holds the round-robin history, the lock hold count and the read-return flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_last_gnt <= 1'b1;
      r_hold_cnt <= '0;
      r_rvalid0  <= 1'b0;
      r_rvalid1  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_last_gnt <= w_last_nxt;
      r_hold_cnt <= w_hold_nxt;
      r_rvalid0  <= w_gnt0 & ~bus.we0;
      r_rvalid1  <= w_gnt1 & ~bus.we1;
    end
  end

  assign w_hold_inc = (r_hold_cnt == HCW'(MAX_HOLD)) ? r_hold_cnt : r_hold_cnt + HCW'(1);

  // Next state. A lock ends when the owner drops lock, when the hold bound is reached,
  // or when the owner goes idle while the other port is waiting.
  always_comb begin
    w_state_nxt = r_state;
    w_hold_nxt  = r_hold_cnt;
    w_last_nxt  = r_last_gnt;
    if (w_gnt0) begin
      w_last_nxt = 1'b0;
    end else if (w_gnt1) begin
      w_last_nxt = 1'b1;
    end
    case (r_state)
      S_IDLE: begin
        w_hold_nxt = '0;
        if (w_gnt0 && bus.lock0 && (MAX_HOLD > 1)) begin
          w_state_nxt = S_OWN0;
          w_hold_nxt  = HCW'(1);
        end else if (w_gnt1 && bus.lock1 && (MAX_HOLD > 1)) begin
          w_state_nxt = S_OWN1;
          w_hold_nxt  = HCW'(1);
        end
      end
      S_OWN0: begin
        w_hold_nxt = w_hold_inc;
        if (!bus.lock0 || (w_hold_inc == HCW'(MAX_HOLD)) || (!bus.req0 && bus.req1)) begin
          w_state_nxt = S_IDLE;
          w_hold_nxt  = '0;
        end
      end
      S_OWN1: begin
        w_hold_nxt = w_hold_inc;
        if (!bus.lock1 || (w_hold_inc == HCW'(MAX_HOLD)) || (!bus.req1 && bus.req0)) begin
          w_state_nxt = S_IDLE;
          w_hold_nxt  = '0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_hold_nxt  = '0;
      end
    endcase
  end

  // Grant and memory-side outputs. Both are combinational, so the memory sees the grant in the same cycle.
  always_comb begin
    w_gnt0      = 1'b0;
    w_gnt1      = 1'b0;
    w_mem_en    = 1'b0;
    w_mem_we    = 1'b0;
    w_mem_addr  = AW'(0);
    w_mem_wdata = DW'(0);
    case (r_state)
      S_IDLE: begin
        if (bus.req0 && bus.req1) begin
          w_gnt0 = r_last_gnt;
          w_gnt1 = ~r_last_gnt;
        end else begin
          w_gnt0 = bus.req0;
          w_gnt1 = bus.req1;
        end
      end
      S_OWN0:  w_gnt0 = bus.req0;
      S_OWN1:  w_gnt1 = bus.req1;
      default: ;
    endcase
    if (reset) begin
      w_gnt0 = 1'b0;
      w_gnt1 = 1'b0;
    end
    if (w_gnt0) begin
      w_mem_en    = 1'b1;
      w_mem_we    = bus.we0;
      w_mem_addr  = bus.addr0;
      w_mem_wdata = bus.wdata0;
    end else if (w_gnt1) begin
      w_mem_en    = 1'b1;
      w_mem_we    = bus.we1;
      w_mem_addr  = bus.addr1;
      w_mem_wdata = bus.wdata1;
    end
  end

  assign bus.gnt0      = w_gnt0;
  assign bus.gnt1      = w_gnt1;
  assign bus.mem_en    = w_mem_en;
  assign bus.mem_we    = w_mem_we;
  assign bus.mem_addr  = w_mem_addr;
  assign bus.mem_wdata = w_mem_wdata;
  assign bus.rvalid0   = r_rvalid0;
  assign bus.rvalid1   = r_rvalid1;
  // The memory drives read data during the return cycle, so it passes straight through to the requester.
  assign bus.rdata0    = r_rvalid0 ? bus.mem_rdata : DW'(0);
  assign bus.rdata1    = r_rvalid1 ? bus.mem_rdata : DW'(0);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small synchronous memory model.
// Inputs change on the falling edge. Outputs are sampled 1 ns later.
module tb_dmem_arbiter;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errs;

  dmem_arbiter_if #(.AW(32), .DW(32)) bus ();

  dmem_arbiter #(.AW(32), .DW(32), .MAX_HOLD(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port synchronous memory: read data is available one cycle after the request.
  logic [31:0] mem [0:255];
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_addr[9:2]] <= bus.mem_wdata;
      else            bus.mem_rdata <= mem[bus.mem_addr[9:2]];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic clr();
    bus.req0 = 1'b0; bus.req1 = 1'b0; bus.we0 = 1'b0; bus.we1 = 1'b0;
    bus.lock0 = 1'b0; bus.lock1 = 1'b0;
    bus.addr0 = 32'h0; bus.addr1 = 32'h0; bus.wdata0 = 32'h0; bus.wdata1 = 32'h0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_errs   = 0;
    bus.mem_rdata = 32'h0;
    reset = 1'b1;
    clr();
    repeat (2) @(negedge clk);

    // Hold requests while reset is high. Nothing may be granted.
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    #1;
    chk("rst_gnt0",    32'(bus.gnt0),    32'd0);
    chk("rst_gnt1",    32'(bus.gnt1),    32'd0);
    chk("rst_mem_en",  32'(bus.mem_en),  32'd0);
    chk("rst_rvalid0", 32'(bus.rvalid0), 32'd0);
    chk("rst_rvalid1", 32'(bus.rvalid1), 32'd0);
    chk("rst_rdata0",  bus.rdata0,       32'd0);

    // CPU write
    @(negedge clk);
    reset = 1'b0;
    clr();
    bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 32'h64; bus.wdata0 = 32'd7;
    #1;
    chk("wr_gnt0",      32'(bus.gnt0),   32'd1);
    chk("wr_gnt1",      32'(bus.gnt1),   32'd0);
    chk("wr_mem_en",    32'(bus.mem_en), 32'd1);
    chk("wr_mem_we",    32'(bus.mem_we), 32'd1);
    chk("wr_mem_addr",  bus.mem_addr,    32'h64);
    chk("wr_mem_wdata", bus.mem_wdata,   32'd7);

    @(negedge clk);
    clr();
    #1;
    chk("idle_mem_en",    32'(bus.mem_en),  32'd0);
    chk("idle_mem_we",    32'(bus.mem_we),  32'd0);
    chk("idle_mem_addr",  bus.mem_addr,     32'h0);
    chk("idle_mem_wdata", bus.mem_wdata,    32'h0);
    chk("wr_no_rvalid0",  32'(bus.rvalid0), 32'd0);

    // Loader read returns the written value one cycle later
    @(negedge clk);
    bus.req1 = 1'b1; bus.addr1 = 32'h64;
    #1;
    chk("rd_gnt1",     32'(bus.gnt1),   32'd1);
    chk("rd_gnt0",     32'(bus.gnt0),   32'd0);
    chk("rd_mem_we",   32'(bus.mem_we), 32'd0);
    chk("rd_mem_addr", bus.mem_addr,    32'h64);
    @(negedge clk);
    clr();
    #1;
    chk("rd_rvalid1", 32'(bus.rvalid1), 32'd1);
    chk("rd_rdata1",  bus.rdata1,       32'd7);
    chk("rd_rvalid0", 32'(bus.rvalid0), 32'd0);
    @(negedge clk);
    #1;
    chk("rd_rvalid1_once", 32'(bus.rvalid1), 32'd0);

    // Tied requests without lock alternate, starting with port 0 because port 1 won last
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.req0 = 1'b1; bus.req1 = 1'b1; bus.addr0 = 32'h64; bus.addr1 = 32'h64;
      #1;
      chk("tie_gnt0", 32'(bus.gnt0), 32'((i % 2) == 0));
      chk("tie_gnt1", 32'(bus.gnt1), 32'((i % 2) == 1));
      chk("tie_excl", 32'(bus.gnt0 & bus.gnt1), 32'd0);
      if (i > 0) chk("tie_rvalid0", 32'(bus.rvalid0), 32'((i % 2) == 1));
    end
    @(negedge clk);
    clr();
    #1;
    chk("tie_last_rvalid1", 32'(bus.rvalid1), 32'd1);
    chk("tie_last_rdata1",  bus.rdata1,       32'd7);

    // Port 0 holds a lock. It keeps the bus for exactly 8 grants, then port 1 wins the tie.
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      bus.req0 = 1'b1; bus.lock0 = 1'b1; bus.req1 = 1'b1;
      bus.we0 = 1'b1; bus.we1 = 1'b1; bus.addr0 = 32'h80; bus.addr1 = 32'h80;
      bus.wdata0 = 32'h11; bus.wdata1 = 32'h22;
      #1;
      chk("lock_gnt0", 32'(bus.gnt0), 32'(i < 8));
      chk("lock_gnt1", 32'(bus.gnt1), 32'(i == 8));
      chk("lock_we_en", 32'(bus.mem_we & ~bus.mem_en), 32'd0);
    end
    @(negedge clk);
    clr();
    #1;
    chk("lock_wr_rvalid0", 32'(bus.rvalid0), 32'd0);
    chk("lock_wr_rvalid1", 32'(bus.rvalid1), 32'd0);

    // A read is granted, then reset is pulsed before the next edge. The read must be dropped.
    @(negedge clk);
    bus.req0 = 1'b1; bus.addr0 = 32'h64;
    #1;
    chk("rr_gnt0", 32'(bus.gnt0), 32'd1);
    #1;
    reset = 1'b1;
    #1;
    chk("rr_gnt0_in_reset",   32'(bus.gnt0),   32'd0);
    chk("rr_mem_en_in_reset", 32'(bus.mem_en), 32'd0);
    @(posedge clk);
    #1;
    chk("rr_rvalid0_dropped", 32'(bus.rvalid0), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    bus.req0 = 1'b1; bus.req1 = 1'b1; bus.addr0 = 32'h64; bus.addr1 = 32'h64;
    #1;
    chk("rr_tie_gnt0",     32'(bus.gnt0),    32'd1);
    chk("rr_tie_gnt1",     32'(bus.gnt1),    32'd0);
    chk("rr_no_late_rvalid", 32'(bus.rvalid0), 32'd0);
    @(negedge clk);
    #1;
    chk("rr_idle_gnt1", 32'(bus.gnt1),    32'd1);
    chk("rr_rvalid0",   32'(bus.rvalid0), 32'd1);
    chk("rr_rdata0",    bus.rdata0,       32'd7);

    // Port 1 locks, then goes quiet while port 0 is idle. Port 0 is served only after the lock is released.
    @(negedge clk);
    clr();
    bus.req1 = 1'b1; bus.lock1 = 1'b1; bus.addr1 = 32'h64;
    #1;
    chk("il_gnt1", 32'(bus.gnt1), 32'd1);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      clr();
      bus.lock1 = 1'b1;
      #1;
      chk("il_hold_gnt0",   32'(bus.gnt0),   32'd0);
      chk("il_hold_gnt1",   32'(bus.gnt1),   32'd0);
      chk("il_hold_mem_en", 32'(bus.mem_en), 32'd0);
    end
    @(negedge clk);
    bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 32'h84; bus.wdata0 = 32'd5;
    #1;
    chk("il_release_gnt0", 32'(bus.gnt0), 32'd0);
    chk("il_release_gnt1", 32'(bus.gnt1), 32'd0);
    @(negedge clk);
    #1;
    chk("il_gnt0",     32'(bus.gnt0),   32'd1);
    chk("il_mem_addr", bus.mem_addr,    32'h84);
    chk("il_mem_we",   32'(bus.mem_we), 32'd1);
    @(negedge clk);
    clr();
    #1;
    chk("end_mem_en", 32'(bus.mem_en), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
